// File: rtl/seq_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_checker_pkg
// Description : Shared constants for the sequence checker: FSM state
//               encodings, err_code values, default symbol codes and the
//               symbol index values produced by seq_symbol_decode.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_checker_pkg;

    // FSM state encodings (4-bit state output)
    localparam logic [3:0] c_ST_IDLE  = 4'd0;
    localparam logic [3:0] c_ST_P1    = 4'd1;
    localparam logic [3:0] c_ST_P2    = 4'd2;
    localparam logic [3:0] c_ST_P3    = 4'd3;
    localparam logic [3:0] c_ST_P4    = 4'd4;
    localparam logic [3:0] c_ST_P5    = 4'd5;
    localparam logic [3:0] c_ST_ERR   = 4'd8;
    localparam logic [3:0] c_ST_ACC_A = 4'd9;
    localparam logic [3:0] c_ST_ACC_B = 4'd10;

    // err_code values
    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] c_ERR_UNKNOWN = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

    // Default symbol codes
    localparam logic [6:0] c_DEF_SYM_P1 = 7'h58;
    localparam logic [6:0] c_DEF_SYM_P2 = 7'h6B;
    localparam logic [6:0] c_DEF_SYM_P3 = 7'h4F;
    localparam logic [6:0] c_DEF_SYM_P4 = 7'h28;
    localparam logic [6:0] c_DEF_SYM_P5 = 7'h0C;
    localparam logic [6:0] c_DEF_SYM_TA = 7'h32;
    localparam logic [6:0] c_DEF_SYM_AB = 7'h16;
    localparam logic [6:0] c_DEF_SYM_TB = 7'h23;

    // Symbol indices from the decoder; steps 1..5 map to 0..4 so that the
    // target step state is simply index + 1.
    localparam logic [2:0] c_SYM_P1 = 3'd0;
    localparam logic [2:0] c_SYM_P2 = 3'd1;
    localparam logic [2:0] c_SYM_P3 = 3'd2;
    localparam logic [2:0] c_SYM_P4 = 3'd3;
    localparam logic [2:0] c_SYM_P5 = 3'd4;
    localparam logic [2:0] c_SYM_TA = 3'd5;
    localparam logic [2:0] c_SYM_AB = 3'd6;
    localparam logic [2:0] c_SYM_TB = 3'd7;

endpackage : seq_checker_pkg
`default_nettype wire

// File: rtl/seq_symbol_decode.sv
`default_nettype none
// ============================================================================
// Module      : seq_symbol_decode
// Description : Combinational code-word classifier. Maps a code word onto a
//               symbol index (steps 1..5, terminate-A, abort, terminate-B)
//               and flags codes that match none of them.
// Ports       : i_code      - presented code word (CODE_W)
//               o_sym_idx   - symbol index, valid when o_unknown is low
//               o_unknown   - high when the code matches no symbol
// Revision    : 1.0 - initial release
// ============================================================================
module seq_symbol_decode
    import seq_checker_pkg::*;
#(
    parameter int                CODE_W = 7,
    parameter logic [CODE_W-1:0] SYM_P1 = CODE_W'(c_DEF_SYM_P1),
    parameter logic [CODE_W-1:0] SYM_P2 = CODE_W'(c_DEF_SYM_P2),
    parameter logic [CODE_W-1:0] SYM_P3 = CODE_W'(c_DEF_SYM_P3),
    parameter logic [CODE_W-1:0] SYM_P4 = CODE_W'(c_DEF_SYM_P4),
    parameter logic [CODE_W-1:0] SYM_P5 = CODE_W'(c_DEF_SYM_P5),
    parameter logic [CODE_W-1:0] SYM_TA = CODE_W'(c_DEF_SYM_TA),
    parameter logic [CODE_W-1:0] SYM_AB = CODE_W'(c_DEF_SYM_AB),
    parameter logic [CODE_W-1:0] SYM_TB = CODE_W'(c_DEF_SYM_TB)
) (
    input  logic [CODE_W-1:0] i_code,
    output logic [2:0]        o_sym_idx,
    output logic              o_unknown
);

    // The if/else chain gives first-match priority when two parameters
    // share the same code.
    always_comb begin
        o_sym_idx = c_SYM_P1;
        o_unknown = 1'b0;
        if      (i_code == SYM_P1) o_sym_idx = c_SYM_P1;
        else if (i_code == SYM_P2) o_sym_idx = c_SYM_P2;
        else if (i_code == SYM_P3) o_sym_idx = c_SYM_P3;
        else if (i_code == SYM_P4) o_sym_idx = c_SYM_P4;
        else if (i_code == SYM_P5) o_sym_idx = c_SYM_P5;
        else if (i_code == SYM_TA) o_sym_idx = c_SYM_TA;
        else if (i_code == SYM_AB) o_sym_idx = c_SYM_AB;
        else if (i_code == SYM_TB) o_sym_idx = c_SYM_TB;
        else                       o_unknown = 1'b1;
    end

endmodule : seq_symbol_decode
`default_nettype wire

// File: rtl/seq_checker_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_checker_param
// Description : Parameterised sequence checker. Tracks a walk over step
//               codes 1..5 (each move to an adjacent step), accepts on
//               terminate-A (from P1..P3) or terminate-B (from P4..P5), and
//               flags illegal moves, aborts, unknown codes and idle timeouts.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous active-high reset
//               clear      - synchronous soft restart to IDLE
//               code_valid - qualifies code for one cycle
//               code       - presented code word (CODE_W)
//               state      - encoded FSM state (registered)
//               done       - high in ACC_A, ACC_B or ERR (registered)
//               err_code   - 0 none, 1 illegal/abort, 2 unknown, 3 timeout
//               step_count - accepted step codes, saturating (CNT_W)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_checker_param
    import seq_checker_pkg::*;
#(
    parameter int                CODE_W  = 7,
    parameter logic [CODE_W-1:0] SYM_P1  = CODE_W'(c_DEF_SYM_P1),
    parameter logic [CODE_W-1:0] SYM_P2  = CODE_W'(c_DEF_SYM_P2),
    parameter logic [CODE_W-1:0] SYM_P3  = CODE_W'(c_DEF_SYM_P3),
    parameter logic [CODE_W-1:0] SYM_P4  = CODE_W'(c_DEF_SYM_P4),
    parameter logic [CODE_W-1:0] SYM_P5  = CODE_W'(c_DEF_SYM_P5),
    parameter logic [CODE_W-1:0] SYM_TA  = CODE_W'(c_DEF_SYM_TA),
    parameter logic [CODE_W-1:0] SYM_AB  = CODE_W'(c_DEF_SYM_AB),
    parameter logic [CODE_W-1:0] SYM_TB  = CODE_W'(c_DEF_SYM_TB),
    parameter int unsigned       TIMEOUT = 0,
    parameter bit                STRICT  = 1'b1,
    parameter int                CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic [3:0]        state,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  step_count
);

    localparam int TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit c_TO_EN  = (TIMEOUT > 0);

    logic [3:0]       r_state;
    logic             r_done;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_step_count;
    logic [TO_W-1:0]  r_idle_cnt;

    logic [2:0]       w_sym_idx;
    logic             w_unknown;
    logic             w_in_step;
    logic [3:0]       w_target;
    logic             w_adjacent;
    logic             w_timeout_fire;

    seq_symbol_decode #(
        .CODE_W (CODE_W),
        .SYM_P1 (SYM_P1),
        .SYM_P2 (SYM_P2),
        .SYM_P3 (SYM_P3),
        .SYM_P4 (SYM_P4),
        .SYM_P5 (SYM_P5),
        .SYM_TA (SYM_TA),
        .SYM_AB (SYM_AB),
        .SYM_TB (SYM_TB)
    ) u_decode (
        .i_code    (code),
        .o_sym_idx (w_sym_idx),
        .o_unknown (w_unknown)
    );

    assign w_in_step = (r_state >= c_ST_P1) && (r_state <= c_ST_P5);

    // Step symbol index k-1 targets state Pk.
    assign w_target  = {1'b0, w_sym_idx} + 4'd1;

    // A step is legal from IDLE or from a neighbouring step. States outside
    // 0..5 never reach this path because terminal states ignore codes.
    assign w_adjacent = (r_state == c_ST_IDLE)
                     || (r_state + 4'd1 == w_target)
                     || (r_state == w_target + 4'd1);

    generate
        if (c_TO_EN) begin : g_timeout
            // Fires in the cycle the idle counter sits at TIMEOUT; the FSM
            // enters ERR on the following edge unless a code arrives.
            assign w_timeout_fire = w_in_step && (r_idle_cnt == TO_W'(TIMEOUT));
        end else begin : g_no_timeout
            assign w_timeout_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state      <= c_ST_IDLE;
            r_done       <= 1'b0;
            r_err_code   <= c_ERR_NONE;
            r_step_count <= '0;
            r_idle_cnt   <= '0;
        end else if (!r_done) begin
            if (code_valid) begin
                r_idle_cnt <= '0;
                if (w_unknown) begin
                    if (w_in_step && STRICT) begin
                        r_state    <= c_ST_ERR;
                        r_err_code <= c_ERR_UNKNOWN;
                        r_done     <= 1'b1;
                    end
                end else begin
                    case (w_sym_idx)
                        c_SYM_TA: begin
                            if (w_in_step) begin
                                r_done <= 1'b1;
                                if (r_state <= c_ST_P3) begin
                                    r_state <= c_ST_ACC_A;
                                end else begin
                                    r_state    <= c_ST_ERR;
                                    r_err_code <= c_ERR_ILLEGAL;
                                end
                            end
                        end
                        c_SYM_TB: begin
                            if (w_in_step) begin
                                r_done <= 1'b1;
                                if (r_state >= c_ST_P4) begin
                                    r_state <= c_ST_ACC_B;
                                end else begin
                                    r_state    <= c_ST_ERR;
                                    r_err_code <= c_ERR_ILLEGAL;
                                end
                            end
                        end
                        c_SYM_AB: begin
                            if (w_in_step) begin
                                r_state    <= c_ST_ERR;
                                r_err_code <= c_ERR_ILLEGAL;
                                r_done     <= 1'b1;
                            end
                        end
                        default: begin
                            if (w_adjacent) begin
                                r_state <= w_target;
                                if (r_step_count != {CNT_W{1'b1}}) begin
                                    r_step_count <= r_step_count + CNT_W'(1);
                                end
                            end else begin
                                r_state    <= c_ST_ERR;
                                r_err_code <= c_ERR_ILLEGAL;
                                r_done     <= 1'b1;
                            end
                        end
                    endcase
                end
            end else if (w_timeout_fire) begin
                r_state    <= c_ST_ERR;
                r_err_code <= c_ERR_TIMEOUT;
                r_done     <= 1'b1;
                r_idle_cnt <= '0;
            end else if (w_in_step && c_TO_EN) begin
                r_idle_cnt <= r_idle_cnt + TO_W'(1);
            end
        end
    end

    assign state      = r_state;
    assign done       = r_done;
    assign err_code   = r_err_code;
    assign step_count = r_step_count;

endmodule : seq_checker_param
`default_nettype wire

// File: tb/tb_seq_checker_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_checker_param
// Description : Scoreboard testbench for seq_checker_param. Three instances
//               (STRICT=1/TIMEOUT=0, STRICT=0/TIMEOUT=3, STRICT=1/TIMEOUT=3)
//               share one stimulus stream; a behavioural model predicts each
//               instance's outputs per cycle and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_checker_param;

    typedef struct {
        int st;
        int err;
        int steps;
        int silent;
    } mdl_t;

    typedef struct {
        int st;
        int done;
        int err;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       code_valid = 1'b0;
    logic [6:0] code = 7'h00;

    logic [3:0] state0, state1, state2;
    logic       done0, done1, done2;
    logic [1:0] err0, err1, err2;
    logic [3:0] cnt0, cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    logic [6:0] syms [0:7] = '{7'h58, 7'h6B, 7'h4F, 7'h28, 7'h0C, 7'h32, 7'h16, 7'h23};
    int         strict_cfg [0:2] = '{1, 0, 1};
    int         tmo_cfg    [0:2] = '{0, 3, 3};
    mdl_t       m [0:2];
    exp_t       q0 [$];
    exp_t       q1 [$];
    exp_t       q2 [$];

    always #5 clk = ~clk;

    seq_checker_param dut0 (
        .clk(clk), .reset(reset), .clear(clear), .code_valid(code_valid), .code(code),
        .state(state0), .done(done0), .err_code(err0), .step_count(cnt0)
    );

    seq_checker_param #(.STRICT(1'b0), .TIMEOUT(3)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .code_valid(code_valid), .code(code),
        .state(state1), .done(done1), .err_code(err1), .step_count(cnt1)
    );

    seq_checker_param #(.STRICT(1'b1), .TIMEOUT(3)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .code_valid(code_valid), .code(code),
        .state(state2), .done(done2), .err_code(err2), .step_count(cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Symbol table position of a code (first match), -1 when unrecognised.
    function automatic int classify(input logic [6:0] cd);
        for (int i = 0; i < 8; i++) begin
            if (cd == syms[i]) return i;
        end
        return -1;
    endfunction

    // Reference behaviour for one clock edge.
    function automatic mdl_t mstep(input mdl_t cur, input bit r, input bit c,
                                   input bit v, input logic [6:0] cd,
                                   input int strict, input int tmo);
        mdl_t n;
        bit   active;
        int   sym;
        int   k;
        n      = cur;
        active = (cur.st >= 1) && (cur.st <= 5);
        if (r || c) begin
            n = '{0, 0, 0, 0};
            return n;
        end
        if (cur.st >= 8) return n;
        if (v) begin
            n.silent = 0;
            sym = classify(cd);
            if (sym >= 0 && sym <= 4) begin
                k = sym + 1;
                if (cur.st == 0 || cur.st - k == 1 || k - cur.st == 1) begin
                    n.st    = k;
                    n.steps = (cur.steps < 15) ? cur.steps + 1 : 15;
                end else begin
                    n.st = 8; n.err = 1;
                end
            end else if (sym == 5) begin
                if (active) begin
                    if (cur.st <= 3) n.st = 9;
                    else begin n.st = 8; n.err = 1; end
                end
            end else if (sym == 6) begin
                if (active) begin n.st = 8; n.err = 1; end
            end else if (sym == 7) begin
                if (active) begin
                    if (cur.st >= 4) n.st = 10;
                    else begin n.st = 8; n.err = 1; end
                end
            end else begin
                if (active && strict != 0) begin n.st = 8; n.err = 2; end
            end
        end else if (tmo > 0 && active) begin
            if (cur.silent == tmo) begin
                n.st = 8; n.err = 3; n.silent = 0;
            end else begin
                n.silent = cur.silent + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(input mdl_t x);
        exp_t e;
        e.st   = x.st;
        e.done = (x.st == 8 || x.st == 9 || x.st == 10) ? 1 : 0;
        e.err  = x.err;
        e.cnt  = x.steps;
        return e;
    endfunction

    task automatic step(input bit r, input bit c, input bit v, input logic [6:0] cd);
        @(negedge clk);
        reset = r; clear = c; code_valid = v; code = cd;
        for (int i = 0; i < 3; i++) begin
            m[i] = mstep(m[i], r, c, v, cd, strict_cfg[i], tmo_cfg[i]);
        end
        q0.push_back(to_exp(m[0]));
        q1.push_back(to_exp(m[1]));
        q2.push_back(to_exp(m[2]));
        @(posedge clk);
    endtask

    task automatic send(input logic [6:0] cd);
        step(1'b0, 1'b0, 1'b1, cd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 7'h00);
    endtask

    task automatic clr();
        step(1'b0, 1'b1, 1'b0, 7'h00);
    endtask

    task automatic cmp(input int id, input exp_t e, input logic [3:0] s,
                       input logic d, input logic [1:0] er, input logic [3:0] cn);
        chk($sformatf("dut%0d_state", id), int'(s), e.st);
        chk($sformatf("dut%0d_done", id), int'(d), e.done);
        chk($sformatf("dut%0d_err_code", id), int'(er), e.err);
        chk($sformatf("dut%0d_step_count", id), int'(cn), e.cnt);
    endtask

    // Monitor: outputs are registered, so each edge presents one response.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin e = q0.pop_front(); cmp(0, e, state0, done0, err0, cnt0); end
        if (q1.size() > 0) begin e = q1.pop_front(); cmp(1, e, state1, done1, err1, cnt1); end
        if (q2.size() > 0) begin e = q2.pop_front(); cmp(2, e, state2, done2, err2, cnt2); end
    end

    initial begin
        int r;
        int n;
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};

        step(1'b1, 1'b0, 1'b0, 7'h00);
        step(1'b1, 1'b0, 1'b1, 7'h58);
        #2;
        chk("reset_state", int'(state0), 0);
        chk("reset_step_count", int'(cnt0), 0);

        // Walk 1,2,3,2 then terminate-A
        clr(); send(7'h58); send(7'h6B); send(7'h4F); send(7'h6B); send(7'h32);
        #2;
        chk("acc_a_state", int'(state0), 9);
        chk("acc_a_done", int'(done0), 1);
        chk("acc_a_step_count", int'(cnt0), 4);

        // Walk 3,4,5 then terminate-B
        clr(); send(7'h4F); send(7'h28); send(7'h0C); send(7'h23);
        #2;
        chk("acc_b_state", int'(state0), 10);
        chk("acc_b_err_code", int'(err0), 0);

        // Illegal jump 1 -> 3, then ERR holds
        clr(); send(7'h58); send(7'h4F);
        #2;
        chk("illegal_state", int'(state0), 8);
        chk("illegal_err_code", int'(err0), 1);
        send(7'h58);
        #2;
        chk("err_hold_state", int'(state0), 8);

        // Unknown code in P1: strict vs lenient
        clr(); send(7'h58); send(7'h7F);
        #2;
        chk("strict_unknown_state", int'(state0), 8);
        chk("strict_unknown_err", int'(err0), 2);
        chk("lenient_unknown_state", int'(state1), 1);

        // Timeout fires after TIMEOUT+1 idle edges
        clr(); send(7'h58); idle(); idle(); idle(); idle();
        #2;
        chk("timeout_state", int'(state2), 8);
        chk("timeout_err_code", int'(err2), 3);
        // Code in firing cycle prevents the timeout
        clr(); send(7'h58); idle(); idle(); idle(); send(7'h6B);
        #2;
        chk("timeout_preempt_state", int'(state2), 2);
        chk("timeout_preempt_err", int'(err2), 0);

        // Clear in P3 with a simultaneous code
        clr(); send(7'h58); send(7'h6B); send(7'h4F);
        step(1'b0, 1'b1, 1'b1, 7'h28);
        #2;
        chk("clear_p3_state", int'(state0), 0);
        chk("clear_p3_step_count", int'(cnt0), 0);
        // Reset in ACC_A with a simultaneous code
        send(7'h58); send(7'h32);
        step(1'b1, 1'b0, 1'b1, 7'h58);
        #2;
        chk("reset_acc_state", int'(state0), 0);
        chk("reset_acc_err_code", int'(err0), 0);

        // step_count saturation
        clr();
        for (int i = 0; i < 18; i++) send((i % 2 == 0) ? 7'h58 : 7'h6B);
        #2;
        chk("sat_step_count", int'(cnt0), 15);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (m[0].st >= 8 && m[2].st >= 8 && $urandom_range(0, 3) == 0) begin
                clr();
            end else if (r < 3) begin
                step(1'b1, 1'b0, 1'($urandom_range(0, 1)), syms[$urandom_range(0, 7)]);
            end else if (r < 7) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), syms[$urandom_range(0, 7)]);
            end else if (r < 15) begin
                n = $urandom_range(2, 5);
                for (int j = 0; j < n; j++) idle();
            end else if (r < 30) begin
                idle();
            end else if (r < 85) begin
                send(syms[$urandom_range(0, 7)]);
            end else begin
                send(7'($urandom));
            end
        end

        idle();
        #2;
        chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_checker_param
`default_nettype wire

// File: doc/seq_checker_param.md
SEQ_CHECKER_PARAM -- requirements
Module: seq_checker_param

Interface
REQ-001 SHALL have parameter CODE_W, default 7, the width of one input code word.
REQ-002 SHALL have parameters SYM_P1..SYM_P5, SYM_TA, SYM_AB and SYM_TB, each CODE_W wide, defaulting to the package codes 7'h58, 7'h6B, 7'h4F, 7'h28, 7'h0C, 7'h32, 7'h16 and 7'h23; these are the step codes 1..5, terminate-A, abort and terminate-B.
REQ-003 SHALL have parameter TIMEOUT, default 0, giving the maximum cycles allowed between codes while active; 0 disables the check.
REQ-004 SHALL have parameter STRICT, default 1; when 1, an unrecognised code while active is an error, and when 0 it is ignored.
REQ-005 SHALL have parameter CNT_W, default 4, the width of step_count.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 clear  input  1  synchronous soft restart to IDLE.
REQ-009 code_valid  input  1  qualifies code for one cycle.
REQ-010 code  input  CODE_W  presented code word.
REQ-011 state  output  4  encoded FSM state.
REQ-012 done  output  1  high while state is ACC_A, ACC_B or ERR.
REQ-013 err_code  output  2  0 = none, 1 = illegal transition or abort, 2 = unknown code, 3 = timeout.
REQ-014 step_count  output  CNT_W  number of accepted step codes, saturating.

Function
REQ-015 SHALL use these state encodings: IDLE=0, P1..P5=1..5, ERR=8, ACC_A=9, ACC_B=10.
REQ-016 SHALL register all outputs; a code sampled with code_valid=1 at edge N SHALL be visible on the outputs after edge N.
REQ-017 SHALL apply the following on a step code k (1..5) while not done:
- move to Pk if the current state is IDLE or an adjacent step (P(k-1) or P(k+1), within 1..5);
- otherwise move to ERR with err_code=1.
REQ-018 SHALL apply the following on a terminate-A code:
- IDLE: ignored;
- P1..P3: move to ACC_A;
- P4..P5: move to ERR with err_code=1.
REQ-019 SHALL apply the following on a terminate-B code:
- IDLE: ignored;
- P4..P5: move to ACC_B;
- P1..P3: move to ERR with err_code=1.
REQ-020 SHALL apply the following on an abort code:
- IDLE: ignored;
- P1..P5: move to ERR with err_code=1.
REQ-021 SHALL apply the following on an unrecognised code:
- in P1..P5 with STRICT=1: move to ERR with err_code=2;
- in IDLE, or with STRICT=0: ignored.
REQ-022 SHALL hold terminal states (ACC_A, ACC_B, ERR) and ignore code_valid until reset or clear.
REQ-023 SHALL increment step_count on each step code that moves the FSM to a Pk, saturating at 2^CNT_W-1.
REQ-024 SHALL run an idle-cycle counter, when TIMEOUT>0, that:
- clears on every code_valid;
- counts only in P1..P5;
- on reaching TIMEOUT, moves the FSM to ERR with err_code=3 on the next edge.
REQ-025 SHALL give a code_valid arriving in the cycle the timeout fires priority over the timeout, so the timeout does not fire.
REQ-026 SHALL give input priority in the order reset > clear > code_valid > timeout.
REQ-027 SHALL treat duplicate parameter codes by taking the first match in the order P1..P5, TA, AB, TB.

Reset
REQ-028 SHALL, on reset or clear, set state=IDLE, done=0, err_code=0, step_count=0 and the idle counter to 0, including when asserted mid-sequence or in a terminal state.
REQ-029 SHALL ignore code_valid in any cycle where reset or clear is high.

Structure
REQ-030 SHALL define the state encodings, the err_code values and the default symbol codes in shared package seq_checker_pkg.
REQ-031 SHALL contain one sub-module, seq_symbol_decode: combinational, mapping code to a symbol index plus an unknown flag.
REQ-032 SHALL have an RTL implementation of 120-400 lines with no latches.

Verification
REQ-033 Codes 58,6B,4F,6B,32 (hex, one per cycle) SHALL drive state 1,2,3,2 then 9, with done=1 and step_count=4.
REQ-034 Codes 4F,28,0C,23 SHALL drive state 3,4,5 then 10, with done=1 and err_code=0.
REQ-035 Codes 58 then 4F SHALL drive state 1 then 8, with err_code=1; a further 58 SHALL leave state at 8.
REQ-036 With STRICT=1, codes 58 then 7F SHALL drive state 8 with err_code=2; with STRICT=0 the same stimulus SHALL leave state at 1.
REQ-037 With TIMEOUT=3, code 58 followed by idle cycles SHALL drive state 8 with err_code=3; a code arriving in the firing cycle SHALL prevent the timeout.
REQ-038 Reset or clear asserted in P3 or in ACC_A SHALL give state 0, step_count 0 and err_code 0 on the next cycle, with a simultaneous code_valid ignored.
